// File: rtl/hybrid_sar_ctrl.sv
// rtl/hybrid_sar_ctrl.sv - successive-approximation controller for hybrid analog tiles
module hybrid_sar_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE_CYC = 1,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             scan,
    input  logic             abort,
    input  logic [CH_W-1:0]  chan_sel,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [CH_W-1:0]  mux_sel,
    output logic             track_en,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [CH_W-1:0]  result_chan,
    output logic             result_valid
);

    localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [BIT_W-1:0] TOP_BIT     = BIT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        SETTLE = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [WIDTH-1:0] decided;
    logic [CH_W-1:0]  next_chan;
    logic [CH_W-1:0]  start_chan;

    // Resolve the current trial bit from the comparator and arm the next one.
    always_comb begin
        decided          = dac_code;
        decided[bit_idx] = cmp_in;
        if (bit_idx != '0) begin
            decided[bit_idx - 1'b1] = 1'b1;
        end
    end

    always_comb begin
        next_chan  = (mux_sel == CH_LAST) ? '0 : mux_sel + 1'b1;
        start_chan = (int'(chan_sel) >= CHANNELS) ? '0 : chan_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= TOP_BIT;
            dac_code     <= '0;
            mux_sel      <= '0;
            track_en     <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_chan  <= '0;
            result_valid <= 1'b0;
        end else if (ena) begin
            result_valid <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                track_en <= 1'b0;
                busy     <= 1'b0;
                cnt      <= '0;
                bit_idx  <= TOP_BIT;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mux_sel  <= start_chan;
                            dac_code <= '0;
                            track_en <= 1'b1;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            bit_idx  <= TOP_BIT;
                            state    <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        if (cnt == SAMPLE_LAST) begin
                            track_en <= 1'b0;
                            dac_code <= MSB_CODE;
                            bit_idx  <= TOP_BIT;
                            cnt      <= '0;
                            state    <= (SETTLE_CYC == 0) ? DECIDE : SETTLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= DECIDE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DECIDE: begin
                        dac_code <= decided;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - 1'b1;
                            state   <= (SETTLE_CYC == 0) ? DECIDE : SETTLE;
                        end else begin
                            result       <= decided;
                            result_chan  <= mux_sel;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                    DONE: begin
                        // dac_code keeps the final code until the next sample window closes.
                        if (scan) begin
                            mux_sel  <= next_chan;
                            track_en <= 1'b1;
                            cnt      <= '0;
                            bit_idx  <= TOP_BIT;
                            state    <= SAMPLE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        track_en <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hybrid_sar_ctrl.sv
// tb/tb_hybrid_sar_ctrl.sv - scoreboard bench for hybrid_sar_ctrl with ideal comparator model
module tb_hybrid_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, scan, abort, cmp_in;
    logic [1:0] chan_sel;
    logic [7:0] dac_code, result;
    logic [1:0] mux_sel, result_chan;
    logic       track_en, busy, result_valid;

    logic [7:0] vin [4];
    logic [7:0] last_res;

    typedef struct {
        logic [7:0] res;
        logic [1:0] ch;
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    hybrid_sar_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .scan(scan),
        .abort(abort), .chan_sel(chan_sel), .cmp_in(cmp_in),
        .dac_code(dac_code), .mux_sel(mux_sel), .track_en(track_en),
        .busy(busy), .result(result), .result_chan(result_chan),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cmp_in = (vin[mux_sel] >= dac_code);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    // Ideal SAR trial i: bits already resolved from vin, plus the bit under test.
    function automatic logic [7:0] trial(input logic [7:0] v, input int i);
        logic [7:0] m;
        m = 8'hFF;
        m = m << (8 - i);
        return (v & m) | (8'h80 >> i);
    endfunction

    task automatic push_exp(input logic [7:0] r, input logic [1:0] ch, input int c);
        exp_t x;
        x.res = r;
        x.ch  = ch;
        x.cyc = c;
        sbq.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dac"}, dac_code, 0);
        check({tag, "_mux"}, mux_sel, 0);
        check({tag, "_track"}, track_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_rchan"}, result_chan, 0);
        check({tag, "_rvalid"}, result_valid, 0);
    endtask

    task automatic convert(input logic [1:0] ch, input bit trials, input bit poke_start);
        int e;
        logic [7:0] v;
        v = vin[ch];
        chan_sel = ch;
        start = 1'b1;
        e = cyc + 1;
        tick(1);
        start = 1'b0;
        chan_sel = 2'd0;
        push_exp(v, ch, e + 18);
        check("track_hi", track_en, 1);
        check("busy_hi", busy, 1);
        if (trials) begin
            for (int i = 0; i < 8; i++) begin
                wait_cyc(e + 2 + 2 * i);
                check("trial_code", dac_code, trial(v, i));
            end
        end
        if (poke_start) begin
            wait_cyc(e + 6);
            start = 1'b1;
            chan_sel = ch + 2'd1;
            tick(1);
            start = 1'b0;
            chan_sel = 2'd0;
        end
        wait_cyc(e + 19);
        check("busy_lo", busy, 0);
        check("final_dac", dac_code, v);
        last_res = v;
    endtask

    // Monitor: pop one expectation per result_valid pulse.
    initial begin
        logic prev_v;
        exp_t x;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (result_valid && !prev_v) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid actual=1 required=0 result=%0h chan=%0d cycle=%0d",
                                 result, result_chan, cyc);
                    end else begin
                        x = sbq.pop_front();
                        check("result", result, x.res);
                        check("result_chan", result_chan, x.ch);
                        check("valid_cycle", cyc, x.cyc);
                    end
                end
                prev_v = result_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [1:0] ch;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; scan = 1'b0; abort = 1'b0; chan_sel = 2'd0;
        for (int i = 0; i < 4; i++) vin[i] = 8'h00;
        last_res = 8'h00;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(1);

        vin[2] = 8'hA5; convert(2'd2, 1'b1, 1'b0);
        vin[0] = 8'h00; convert(2'd0, 1'b1, 1'b0);
        vin[1] = 8'hFF; convert(2'd1, 1'b1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) vin[i] = 8'($urandom_range(0, 255));
            ch = 2'($urandom_range(0, 3));
            convert(ch, n < 2, 1'b0);
        end

        vin[3] = 8'($urandom_range(0, 255));
        convert(2'd3, 1'b0, 1'b1);

        // Round-robin scan from channel 3, dropping scan during the fourth conversion.
        for (int i = 0; i < 4; i++) vin[i] = 8'(i * 8'h11);
        scan = 1'b1; chan_sel = 2'd3; start = 1'b1;
        e = cyc + 1;
        tick(1);
        start = 1'b0; chan_sel = 2'd0;
        for (int k = 0; k < 4; k++) push_exp(vin[(3 + k) % 4], 2'((3 + k) % 4), e + 18 + 19 * k);
        wait_cyc(e + 60);
        scan = 1'b0;
        wait_cyc(e + 75);
        check("scan_busy_last", busy, 1);
        tick(1);
        check("scan_busy_lo", busy, 0);
        last_res = 8'h22;

        // Abort while settling bit 4.
        vin[1] = 8'($urandom_range(0, 255));
        chan_sel = 2'd1; start = 1'b1;
        e = cyc + 1;
        tick(1);
        start = 1'b0;
        wait_cyc(e + 8);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_track", track_en, 0);
        check("abort_result", result, last_res);
        tick(25);
        check("abort_idle", busy, 0);

        // Freeze for five cycles mid-conversion.
        vin[2] = 8'($urandom_range(0, 255));
        chan_sel = 2'd2; start = 1'b1;
        e = cyc + 1;
        tick(1);
        start = 1'b0;
        push_exp(vin[2], 2'd2, e + 23);
        wait_cyc(e + 5);
        ena = 1'b0;
        tick(5);
        ena = 1'b1;
        wait_cyc(e + 24);
        check("ena_busy_lo", busy, 0);
        last_res = vin[2];

        // Reset in the middle of a conversion.
        vin[0] = 8'($urandom_range(0, 255));
        chan_sel = 2'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_all_zero("midreset");
        last_res = 8'h00;
        tick(25);

        vin[0] = 8'($urandom_range(0, 255));
        convert(2'd0, 1'b0, 1'b0);

        for (int t = 0; t < 100 && sbq.size() != 0; t++) tick(1);
        check("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
